// File: rtl/matrix_rx_pkg.sv
// matrix_pkg: shared constants and helpers for the LED-matrix receiver.
//   MATRIX_N      - rows/columns per chain (16)
//   COORD_W       - width of a row/column index (4)
//   CNT_W         - width of a per-chain bit counter (5, saturating at 31)
//   onehot_t      - decode result: valid flag plus bit index
//   onehot_decode - returns {valid = exactly one bit set, idx = that bit}
package matrix_pkg;

  localparam int MATRIX_N = 16;
  localparam int COORD_W  = 4;
  localparam int CNT_W    = 5;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] idx;
  } onehot_t;

  // idx is only meaningful when valid is set; with several bits set it
  // reports the highest one, which callers ignore.
  function automatic onehot_t onehot_decode(input logic [MATRIX_N-1:0] v);
    onehot_t     res;
    int unsigned ones;
    res  = '0;
    ones = 0;
    for (int i = 0; i < MATRIX_N; i++) begin
      if (v[i]) begin
        ones++;
        res.idx = COORD_W'(i);
      end
    end
    res.valid = (ones == 1);
    return res;
  endfunction

endpackage

// File: rtl/matrix_rx_if.sv
// matrix_rx_if: the six LED-matrix driver lines.
//   rclk/rsdi - row chain shift clock and data
//   cclk/csdi - column chain shift clock and data
//   le        - latch enable (rising edge latches both chains)
//   oeb       - output enable, active low
// master: the display driver (drives the lines); slave: the receiver.
interface matrix_rx_if;
  logic rclk;
  logic rsdi;
  logic cclk;
  logic csdi;
  logic le;
  logic oeb;

  modport master (output rclk, rsdi, cclk, csdi, le, oeb);
  modport slave  (input  rclk, rsdi, cclk, csdi, le, oeb);
endinterface

// File: rtl/matrix_rx_lane.sv
// sr_rx_lane: one serial chain (row or column) of the matrix receiver.
// Synchronises the chain clock and data, detects rising edges of the
// synchronised clock, shifts data into a 16-bit register (LSB in) and
// counts shifts with a counter saturating at 31.
//   clk, reset       - system clock, asynchronous active-high reset
//   sclk, sdi        - asynchronous chain clock and data
//   clr              - clears the counter (latch in progress)
//   sr_next          - shift register value including this cycle's shift
//   cnt_next         - bit count including this cycle's shift
// The "next" values are exported so a latch coinciding with a shift
// captures the post-shift state and counts that final bit.
module sr_rx_lane
  import matrix_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                sdi,
  input  logic                clr,
  output logic [MATRIX_N-1:0] sr_next,
  output logic [CNT_W-1:0]    cnt_next
);

  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] sdi_sync_reg;
  logic                   sclk_prev_reg;
  logic [MATRIX_N-1:0]    sr_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   sclk_s;
  logic                   sdi_s;
  logic                   shift;

  // Clock and data share the same depth so they stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_reg <= '0;
      sdi_sync_reg  <= '0;
      sclk_prev_reg <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      sdi_sync_reg  <= {sdi_sync_reg[SYNC_STAGES-2:0], sdi};
      sclk_prev_reg <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_reg[SYNC_STAGES-1];
  assign shift  = sclk_s & ~sclk_prev_reg;

  always_comb begin
    sr_next  = sr_reg;
    cnt_next = cnt_reg;
    if (shift) begin
      sr_next = {sr_reg[MATRIX_N-2:0], sdi_s};
      if (cnt_reg != '1) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      sr_reg  <= sr_next;
      cnt_reg <= clr ? '0 : cnt_next;
    end
  end

endmodule

// File: rtl/matrix_rx.sv
// matrix_rx: LED-matrix shift-register receiver.
// Oversamples the driver lines, reconstructs the latched row/column
// patterns, decodes a single lit pixel and accumulates a 16x16 frame.
//   clk, reset        - system clock, asynchronous active-high reset
//   lines             - driver lines (matrix_rx_if.slave)
//   row_q, col_q      - latched patterns, normalised so 1 = selected/lit
//   latch_stb         - one-cycle pulse when row_q/col_q update
//   len_err           - sticky: a latch saw a chain bit count != 16
//   x, y, pix_valid   - lit pixel column/row, valid while one-hot and oeb=0
//   frame_stb         - one-cycle pulse when a frame is copied to display
//   rd_x, rd_y, rd_pix- combinational display-buffer read
module matrix_rx
  import matrix_pkg::*;
#(
  parameter logic ROW_ACTIVE  = 1'b1,
  parameter logic COL_ACTIVE  = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  matrix_rx_if.slave          lines,
  output logic [MATRIX_N-1:0] row_q,
  output logic [MATRIX_N-1:0] col_q,
  output logic                latch_stb,
  output logic                len_err,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic                pix_valid,
  output logic                frame_stb,
  input  logic [COORD_W-1:0]  rd_x,
  input  logic [COORD_W-1:0]  rd_y,
  output logic                rd_pix
);

  logic [SYNC_STAGES-1:0] le_sync_reg;
  logic [SYNC_STAGES-1:0] oeb_sync_reg;
  logic                   le_prev_reg;
  logic                   le_s;
  logic                   oeb_s;
  logic                   le_rise;

  logic [MATRIX_N-1:0]    row_sr_next;
  logic [MATRIX_N-1:0]    col_sr_next;
  logic [CNT_W-1:0]       row_cnt_next;
  logic [CNT_W-1:0]       col_cnt_next;
  logic [MATRIX_N-1:0]    row_new;
  logic [MATRIX_N-1:0]    col_new;
  onehot_t                row_new_dec;
  onehot_t                row_q_dec;
  onehot_t                col_q_dec;

  logic [COORD_W-1:0]     p_reg;
  logic                   p_valid_reg;
  logic                   frame_hit;
  logic                   wrap;

  logic [MATRIX_N-1:0]    disp_rows [MATRIX_N];

  // ---------------------------------------------------------------- lanes
  sr_rx_lane #(.SYNC_STAGES(SYNC_STAGES)) u_row_lane (
    .clk      (clk),
    .reset    (reset),
    .sclk     (lines.rclk),
    .sdi      (lines.rsdi),
    .clr      (le_rise),
    .sr_next  (row_sr_next),
    .cnt_next (row_cnt_next)
  );

  sr_rx_lane #(.SYNC_STAGES(SYNC_STAGES)) u_col_lane (
    .clk      (clk),
    .reset    (reset),
    .sclk     (lines.cclk),
    .sdi      (lines.csdi),
    .clr      (le_rise),
    .sr_next  (col_sr_next),
    .cnt_next (col_cnt_next)
  );

  // ------------------------------------------------------- le/oeb syncs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      le_sync_reg  <= '0;
      oeb_sync_reg <= '0;
      le_prev_reg  <= 1'b0;
    end else begin
      le_sync_reg  <= {le_sync_reg[SYNC_STAGES-2:0], lines.le};
      oeb_sync_reg <= {oeb_sync_reg[SYNC_STAGES-2:0], lines.oeb};
      le_prev_reg  <= le_s;
    end
  end

  assign le_s    = le_sync_reg[SYNC_STAGES-1];
  assign oeb_s   = oeb_sync_reg[SYNC_STAGES-1];
  assign le_rise = le_s & ~le_prev_reg;

  // Normalise polarity so that 1 always means selected row / lit column.
  assign row_new     = row_sr_next ~^ {MATRIX_N{ROW_ACTIVE}};
  assign col_new     = col_sr_next ~^ {MATRIX_N{COL_ACTIVE}};
  assign row_new_dec = onehot_decode(row_new);

  // A row index at or below the previous one means the scan wrapped.
  assign frame_hit = le_rise & row_new_dec.valid;
  assign wrap      = p_valid_reg && (row_new_dec.idx <= p_reg);

  // ---------------------------------------------------------------- latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q       <= '0;
      col_q       <= '0;
      latch_stb   <= 1'b0;
      len_err     <= 1'b0;
      frame_stb   <= 1'b0;
      p_reg       <= '0;
      p_valid_reg <= 1'b0;
    end else begin
      latch_stb <= le_rise;
      frame_stb <= frame_hit & wrap;
      if (le_rise) begin
        row_q <= row_new;
        col_q <= col_new;
        if ((row_cnt_next != CNT_W'(MATRIX_N)) ||
            (col_cnt_next != CNT_W'(MATRIX_N))) begin
          len_err <= 1'b1;
        end
      end
      if (frame_hit) begin
        p_reg       <= row_new_dec.idx;
        p_valid_reg <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------- decode
  assign row_q_dec = onehot_decode(row_q);
  assign col_q_dec = onehot_decode(col_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      pix_valid <= 1'b0;
    end else begin
      if (col_q_dec.valid) begin
        x <= col_q_dec.idx;
      end
      if (row_q_dec.valid) begin
        y <= row_q_dec.idx;
      end
      pix_valid <= row_q_dec.valid & col_q_dec.valid & ~oeb_s;
    end
  end

  // ------------------------------------------------------- frame buffers
  // On a wrap every row copies acc into disp and clears, except the row
  // being latched, which takes the new column pattern.
  genvar gi;
  generate
    for (gi = 0; gi < MATRIX_N; gi++) begin : g_row
      logic [MATRIX_N-1:0] acc_reg;
      logic [MATRIX_N-1:0] disp_reg;
      logic                row_sel;

      assign row_sel = (row_new_dec.idx == COORD_W'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          acc_reg  <= '0;
          disp_reg <= '0;
        end else if (frame_hit) begin
          if (wrap) begin
            disp_reg <= acc_reg;
            acc_reg  <= row_sel ? col_new : '0;
          end else if (row_sel) begin
            acc_reg <= col_new;
          end
        end
      end

      assign disp_rows[gi] = disp_reg;
    end
  endgenerate

  assign rd_pix = disp_rows[rd_y][rd_x];

endmodule

// File: tb/tb_matrix_rx.sv
// tb_matrix_rx: directed self-checking bench for matrix_rx.
module tb_matrix_rx;
  import matrix_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] row_q, col_q;
  logic        latch_stb, len_err, pix_valid, frame_stb, rd_pix;
  logic [3:0]  x, y, rd_x, rd_y;

  int tests = 0;
  int fails = 0;

  matrix_rx_if mif ();

  matrix_rx dut (
    .clk       (clk),
    .reset     (reset),
    .lines     (mif),
    .row_q     (row_q),
    .col_q     (col_q),
    .latch_stb (latch_stb),
    .len_err   (len_err),
    .x         (x),
    .y         (y),
    .pix_valid (pix_valid),
    .frame_stb (frame_stb),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_pix    (rd_pix)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2);
  endtask

  // One bit period on either/both chains; data is set up 2 clk before
  // the rising edge and held 2 clk after the falling edge.
  task automatic shift_step(input logic do_r, input logic rb, input logic do_c, input logic cb);
    mif.rsdi = rb;
    mif.csdi = cb;
    wait_clk(2);
    if (do_r) mif.rclk = 1'b1;
    if (do_c) mif.cclk = 1'b1;
    wait_clk(2);
    mif.rclk = 1'b0;
    mif.cclk = 1'b0;
    wait_clk(2);
  endtask

  // Sends the first rn/cn bits of rbits/cbits, MSB first.
  task automatic send_bits(input logic [15:0] rbits, input int rn,
                           input logic [15:0] cbits, input int cn);
    for (int k = 0; k < 16; k++) begin
      if (k < rn || k < cn)
        shift_step(k < rn, rbits[15-k], k < cn, cbits[15-k]);
    end
  endtask

  // Pulses le (optionally with a final cclk rise in the same instant) and
  // counts latch_stb / frame_stb pulses seen while it is high.
  task automatic do_latch(input logic with_c, input logic cb, output int nl, output int nf);
    nl = 0;
    nf = 0;
    if (with_c) begin
      mif.csdi = cb;
      wait_clk(2);
      mif.cclk = 1'b1;
    end
    mif.le = 1'b1;
    repeat (10) begin
      @(negedge clk);
      nl += int'(latch_stb);
      nf += int'(frame_stb);
    end
    mif.le   = 1'b0;
    mif.cclk = 1'b0;
    wait_clk(4);
  endtask

  initial begin
    int          nl, nf, bad;
    logic [15:0] rb, cb;

    mif.rclk = 0; mif.rsdi = 0; mif.cclk = 0; mif.csdi = 0;
    mif.le = 0; mif.oeb = 0;
    rd_x = 0; rd_y = 0;

    // Reset state
    wait_clk(3);
    reset = 1'b0;
    wait_clk(3);
    check("rst_row_q", row_q, 0);
    check("rst_col_q", col_q, 0);
    check("rst_latch_stb", latch_stb, 0);
    check("rst_frame_stb", frame_stb, 0);
    check("rst_len_err", len_err, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_pix_valid", pix_valid, 0);
    bad = 0;
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) begin
        rd_x = 4'(xx); rd_y = 4'(yy); #1;
        if (rd_pix !== 1'b0) bad++;
      end
    check("rst_rd_pix_nonzero_count", bad, 0);

    // Single pixel: row 3, column 5
    send_bits(16'h0008, 16, 16'hFFDF, 16);
    do_latch(1'b0, 1'b0, nl, nf);
    check("px_latch_stb_pulses", nl, 1);
    check("px_frame_stb_pulses", nf, 0);
    check("px_row_q", row_q, 32'h0008);
    check("px_col_q", col_q, 32'h0020);
    check("px_len_err", len_err, 0);
    check("px_x", x, 5);
    check("px_y", y, 3);
    check("px_pix_valid", pix_valid, 1);
    @(negedge clk);
    mif.oeb = 1'b1;
    @(negedge clk); @(negedge clk);
    check("oeb_pix_valid_2cyc", pix_valid, 1);
    @(negedge clk);
    check("oeb_pix_valid_3cyc", pix_valid, 0);
    mif.oeb = 1'b0;
    wait_clk(4);

    // Final cclk rise coincides with le rise: row 2, column 7
    do_reset();
    send_bits(16'h0004, 16, 16'hFF7F, 15);
    do_latch(1'b1, 1'b1, nl, nf);
    check("sim_latch_stb_pulses", nl, 1);
    check("sim_row_q", row_q, 32'h0004);
    check("sim_col_q", col_q, 32'h0080);
    check("sim_len_err", len_err, 0);
    check("sim_x", x, 7);
    check("sim_y", y, 2);

    // Short row chain sets sticky len_err
    send_bits(16'h0010, 15, 16'hFFEF, 16);
    do_latch(1'b0, 1'b0, nl, nf);
    check("short_len_err", len_err, 1);
    send_bits(16'h0002, 16, 16'hFFFD, 16);
    do_latch(1'b0, 1'b0, nl, nf);
    check("sticky_row_q", row_q, 32'h0002);
    check("sticky_col_q", col_q, 32'h0002);
    check("sticky_len_err", len_err, 1);

    // Reset in the middle of a shift sequence
    send_bits(16'hFFFF, 8, 16'h0000, 8);
    reset = 1'b1;
    wait_clk(2);
    check("midrst_row_q", row_q, 0);
    check("midrst_len_err", len_err, 0);
    reset = 1'b0;
    wait_clk(2);
    send_bits(16'h0010, 16, 16'hFFFE, 16);
    do_latch(1'b0, 1'b0, nl, nf);
    check("midrst_fresh_row_q", row_q, 32'h0010);
    check("midrst_fresh_col_q", col_q, 32'h0001);
    check("midrst_fresh_len_err", len_err, 0);

    // Diagonal frame scan, then row 0 again wraps
    do_reset();
    for (int r = 0; r < 16; r++) begin
      rb = 16'h0001 << r;
      cb = ~rb;
      send_bits(rb, 16, cb, 16);
      do_latch(1'b0, 1'b0, nl, nf);
      if (r == 0 || r == 15) begin
        check($sformatf("scan_r%0d_frame_stb", r), nf, 0);
        check($sformatf("scan_r%0d_y", r), y, r);
      end
    end
    rd_x = 0; rd_y = 0; #1;
    check("prewrap_rd_pix_00", rd_pix, 0);
    send_bits(16'h0001, 16, 16'hFFFE, 16);
    do_latch(1'b0, 1'b0, nl, nf);
    check("wrap_frame_stb_pulses", nf, 1);
    check("wrap_latch_stb_pulses", nl, 1);
    check("wrap_len_err", len_err, 0);
    bad = 0;
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) begin
        rd_x = 4'(xx); rd_y = 4'(yy); #1;
        if (rd_pix !== (xx == yy)) bad++;
      end
    check("wrap_diag_bad_pixels", bad, 0);
    rd_x = 4'd9; rd_y = 4'd9; #1;
    check("wrap_rd_pix_99", rd_pix, 1);
    rd_x = 4'd3; rd_y = 4'd9; #1;
    check("wrap_rd_pix_39", rd_pix, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_rx.md
# matrix_rx

Serial-to-parallel receiver for the LED-matrix shift-register interface (row chain: rclk/rsdi; column chain: cclk/csdi; le, oeb). It oversamples the six lines on the system clock and reconstructs the latched row/column patterns. It decodes a single lit pixel and accumulates a 16x16 frame image. It sits on the board-side pins, or in loopback inside the bench, to check what the display driver actually sent.

## Interface
- ROW_ACTIVE, 1: rsdi level that selects a row; row_q is normalised so 1 = selected.
- COL_ACTIVE, 0: csdi level that lights a column; col_q is normalised so 1 = lit.
- SYNC_STAGES, 2: flip-flop stages per input synchroniser (>=2).
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- rclk, rsdi, cclk, csdi, le, oeb  in  1 each  asynchronous external lines.
- row_q  out  16  latched row pattern (bit i = row i).
- col_q  out  16  latched column pattern (bit i = column i).
- latch_stb  out  1  one-cycle pulse; row_q/col_q updated this cycle.
- len_err  out  1  sticky; a latch occurred with a row or column bit count != 16.
- x, y  out  4 each  column/row index of the lit pixel.
- pix_valid  out  1  high while row_q and col_q are each one-hot and synchronised oeb is 0.
- frame_stb  out  1  one-cycle pulse when a completed frame is copied to the display buffer.
- rd_x, rd_y  in  4 each  display-buffer read address.
- rd_pix  out  1  display-buffer bit [rd_y][rd_x], combinational.

## Operation
- All six inputs pass through SYNC_STAGES synchronisers. Rising edges of rclk, cclk and le are detected against the last synchronised sample.
- rclk rise: row shift register shifts left, synchronised rsdi enters bit 0. After 16 shifts, the first bit sent is at bit 15. cclk/csdi work the same way for columns.
- Each chain has a 5-bit bit counter that increments per shift and saturates at 31.
- le rise: row_q <= shift reg XNOR ROW_ACTIVE (col likewise); latch_stb = 1. If either counter != 16, set len_err. Both counters clear to 0. Shift registers are not cleared.
- Simultaneous shift and le edge in one cycle: the shift is applied first, and the latch captures the post-shift value. The shift is counted in the closing latch, and the new count restarts at 0.
- x = index of the set bit in col_q, y = index of the set bit in row_q. Both hold their last one-hot values when not one-hot.
- Frame accumulation, on each latch whose new row_q is one-hot with index r:
  - If a previous row index p is valid and r <= p (scan wrapped): copy acc to disp, clear acc, then write acc[r] <= col_q; frame_stb pulses.
  - Otherwise: acc[r] <= col_q.
  - In both cases p <= r, valid.
- A latch with a non-one-hot row_q does not touch acc, disp or p.

## Timing
- Reset values: row_q = 0, col_q = 0, shift regs = 0, counters = 0, len_err = 0, latch_stb = 0, frame_stb = 0, x = 0, y = 0, pix_valid = 0, acc = 0, disp = 0, p invalid, synchronisers = 0.
- External edge to internal action: SYNC_STAGES + 1 clk cycles (3 at default).
- External line limits: each level held >= 2 clk; rsdi/csdi stable from 1 clk before to 1 clk after their clock edge. Faster signalling is unsupported; the block only has to keep its state consistent.
- latch_stb, row_q/col_q update, len_err set and frame_stb all occur in the same cycle. x, y and pix_valid follow 1 cycle later (registered). The disp copy is visible on rd_pix the cycle after frame_stb.
- Reset asserted mid-shift or mid-frame: all state returns to reset values immediately. The first latch after reset carries whatever bits were shifted since reset, and len_err applies to it normally.

## Structure
- Package matrix_pkg: MATRIX_N = 16, COORD_W = 4, CNT_W = 5, plus a one-hot-to-index function with an is-one-hot result.
- Sub-module sr_rx_lane: one synchroniser pair (clock + data), edge detector, 16-bit shift register and saturating counter. Instantiated twice (row, column). le and oeb use plain synchronisers in the top level.
- Top level holds the latch logic, decode, p tracking, and the acc/disp arrays (2 x 256 bits).

## Test plan
- Reset, idle lines -> all outputs 0; rd_pix = 0 for all 256 addresses.
- Shift rsdi = only bit for row 3, csdi all 1 except column 5 at 0, pulse le, oeb = 0 -> row_q = 0x0008, col_q = 0x0020, latch_stb one pulse, next cycle x = 5, y = 3, pix_valid = 1; oeb = 1 -> pix_valid = 0 after 3 cycles.
- Send 15 row bits, then le -> len_err = 1 and stays 1 through later correct 16-bit latches until reset.
- Scan rows 0..15 with a diagonal (col = row), then row 0 again -> frame_stb pulses once at the second row-0 latch; rd_pix = 1 exactly where rd_x == rd_y.
- Final cclk rise and le rise synchronised in the same cycle -> latch includes that bit, no len_err.
- Assert reset after 8 row bits, release, send 16 fresh bits + le -> row_q reflects only the fresh bits, len_err = 0.
